// File: rtl/arb_rom.sv
`default_nettype none
// ============================================================================
// Module  : arb_rom
// Brief   : Two-requester round-robin burst reader in front of a small ROM.
// Rev     : 1.0
// ============================================================================
module arb_rom #(
  parameter int N_PAL = 12,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] dir0,
  input  logic [AW-1:0] dir1,
  input  logic [3:0]    len0,
  input  logic [3:0]    len1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          valid0,
  output logic          valid1,
  output logic          fin0,
  output logic          fin1,
  output logic          err,
  output logic [AW-1:0] dato,
  output logic [AW-1:0] rom_dir,
  input  logic [AW-1:0] rom_dato
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [31:0]   C_NPAL = 32'(N_PAL);
  localparam logic [AW-1:0] C_LAST = AW'(N_PAL - 1);
  localparam logic [AW-1:0] C_ONE  = AW'(1);

  state_t        r_state, w_nxt_state;
  logic          r_owner, w_nxt_owner;
  logic          r_last,  w_nxt_last;
  logic [3:0]    r_cnt,   w_nxt_cnt;
  logic [AW-1:0] r_addr,  w_nxt_addr;
  logic [AW-1:0] r_dato,  w_nxt_dato;
  logic [1:0]    r_gnt,   w_nxt_gnt;
  logic [1:0]    r_valid, w_nxt_valid;
  logic [1:0]    r_fin,   w_nxt_fin;
  logic          r_err,   w_nxt_err;

  logic          w_pick1;
  logic [AW-1:0] w_sel_dir;
  logic [3:0]    w_sel_len;
  logic          w_bad;

  // r_last is the requester served most recently; reset value 1 hands priority to 0
  assign w_pick1   = req1 & (~req0 | ~r_last);
  assign w_sel_dir = w_pick1 ? dir1 : dir0;
  assign w_sel_len = w_pick1 ? len1 : len0;
  assign w_bad     = (w_sel_len == 4'd0) || (32'(w_sel_len) > C_NPAL) ||
                     (32'(w_sel_dir) >= C_NPAL);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_nxt_last  = r_last;
    w_nxt_cnt   = r_cnt;
    w_nxt_addr  = r_addr;
    w_nxt_dato  = r_dato;
    w_nxt_gnt   = 2'b00;
    w_nxt_valid = 2'b00;
    w_nxt_fin   = 2'b00;
    w_nxt_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_nxt_owner        = w_pick1;
          w_nxt_last         = w_pick1;
          w_nxt_gnt[w_pick1] = 1'b1;
          w_nxt_addr         = w_sel_dir;
          w_nxt_cnt          = w_sel_len;
          w_nxt_state        = w_bad ? S_ERR : S_READ;
        end
      end
      S_READ: begin
        w_nxt_dato           = rom_dato;
        w_nxt_valid[r_owner] = 1'b1;
        w_nxt_cnt            = r_cnt - 4'd1;
        w_nxt_addr           = (r_addr == C_LAST) ? '0 : r_addr + C_ONE;
        if (r_cnt == 4'd1) begin
          w_nxt_fin[r_owner] = 1'b1;
          w_nxt_state        = S_IDLE;
        end
      end
      S_ERR: begin
        w_nxt_err          = 1'b1;
        w_nxt_fin[r_owner] = 1'b1;
        w_nxt_state        = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_dato  <= '0;
      r_gnt   <= 2'b00;
      r_valid <= 2'b00;
      r_fin   <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_owner <= w_nxt_owner;
      r_last  <= w_nxt_last;
      r_cnt   <= w_nxt_cnt;
      r_addr  <= w_nxt_addr;
      r_dato  <= w_nxt_dato;
      r_gnt   <= w_nxt_gnt;
      r_valid <= w_nxt_valid;
      r_fin   <= w_nxt_fin;
      r_err   <= w_nxt_err;
    end
  end

  assign gnt0    = r_gnt[0];
  assign gnt1    = r_gnt[1];
  assign valid0  = r_valid[0];
  assign valid1  = r_valid[1];
  assign fin0    = r_fin[0];
  assign fin1    = r_fin[1];
  assign err     = r_err;
  assign dato    = r_dato;
  assign rom_dir = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_arb_rom.sv
`default_nettype none
// ============================================================================
// Module  : tb_arb_rom
// Brief   : Scoreboard bench for arb_rom with a 12-word ROM model.
// Rev     : 1.0
// ============================================================================
module tb_arb_rom;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] dir0 = '0, dir1 = '0;
  logic [3:0] len0 = '0, len1 = '0;
  logic       gnt0, gnt1, valid0, valid1, fin0, fin1, err;
  logic [7:0] dato, rom_dir, rom_dato;

  logic [7:0] rom [0:11];

  typedef struct {
    int         who;
    logic       is_err;
    logic [7:0] data;
    logic       fin;
  } ev_t;

  ev_t sb[$];
  ev_t e;
  int  n_checks = 0;
  int  n_fail   = 0;

  arb_rom #(.N_PAL(12), .AW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .dir0(dir0), .dir1(dir1),
    .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1),
    .valid0(valid0), .valid1(valid1),
    .fin0(fin0), .fin1(fin1),
    .err(err), .dato(dato),
    .rom_dir(rom_dir), .rom_dato(rom_dato)
  );

  initial forever #5 clk = ~clk;

  initial begin
    rom[0] = 8'd90;  rom[1] = 8'd80;  rom[2]  = 8'd40;  rom[3]  = 8'd60;
    rom[4] = 8'd70;  rom[5] = 8'd40;  rom[6]  = 8'd50;  rom[7]  = 8'd55;
    rom[8] = 8'd65;  rom[9] = 8'd100; rom[10] = 8'd101; rom[11] = 8'd102;
  end

  always_comb begin
    rom_dato = 8'h00;
    if (rom_dir < 8'd12) rom_dato = rom[rom_dir[3:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_word(input int who, input logic [7:0] d, input logic f);
    sb.push_back('{who, 1'b0, d, f});
  endtask

  task automatic exp_err(input int who);
    sb.push_back('{who, 1'b1, 8'h00, 1'b1});
  endtask

  // Output vector {valid0,valid1,fin0,fin1,err,dato} checked against each queued event
  always @(negedge clk) begin
    if (!rst && (valid0 || valid1 || err)) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {29'd0, valid0, valid1, err}, 32'd0);
      end else begin
        logic [12:0] act_v, exp_v;
        logic [1:0]  own;
        e     = sb.pop_front();
        own   = (e.who != 0) ? 2'b01 : 2'b10;
        act_v = {valid0, valid1, fin0, fin1, err, dato};
        exp_v = {e.is_err ? 2'b00 : own,
                 (e.fin || e.is_err) ? own : 2'b00,
                 e.is_err,
                 e.is_err ? dato : e.data};
        check(e.is_err ? "err_event" : "data_word", {19'd0, act_v}, {19'd0, exp_v});
      end
    end else if (!rst && (fin0 || fin1)) begin
      check("fin_without_valid", {30'd0, fin0, fin1}, 32'd0);
    end
  end

  task automatic do_req(input bit who, input logic [7:0] d, input logic [3:0] l, output int waited);
    if (who) begin req1 = 1'b1; dir1 = d; len1 = l; end
    else     begin req0 = 1'b1; dir0 = d; len0 = l; end
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!(who ? gnt1 : gnt0) && waited < 20);
    check("grant_seen",  {31'd0, who ? gnt1 : gnt0}, 32'd1);
    check("grant_other", {31'd0, who ? gnt0 : gnt1}, 32'd0);
    // Scribble the request inputs; the running burst must not notice
    req0 = 1'b0; req1 = 1'b0;
    dir0 = 8'hff; dir1 = 8'hff; len0 = 4'hf; len1 = 4'hf;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
  endtask

  logic [7:0] wrap_dir [4];
  logic [7:0] bnd_data [12];
  logic [7:0] rej_dir  [3];
  logic [3:0] rej_len  [3];

  initial begin
    int w;
    int got;
    int whos [3];
    int cyc  [3];

    wrap_dir = '{8'd10, 8'd11, 8'd0, 8'd1};
    bnd_data = '{8'd102, 8'd90, 8'd80, 8'd40, 8'd60, 8'd70,
                 8'd40, 8'd50, 8'd55, 8'd65, 8'd100, 8'd101};
    rej_dir  = '{8'd12, 8'd0, 8'd0};
    rej_len  = '{4'd2, 4'd0, 4'd13};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", {25'd0, gnt0, gnt1, valid0, valid1, fin0, fin1, err}, 32'd0);
    check("reset_dato", {24'd0, dato}, 32'd0);
    check("reset_romdir", {24'd0, rom_dir}, 32'd0);
    rst = 1'b0;

    // Single burst from requester 0
    exp_word(0, 8'd90, 1'b0);
    exp_word(0, 8'd80, 1'b0);
    exp_word(0, 8'd40, 1'b1);
    do_req(1'b0, 8'd0, 4'd3, w);
    check("single_start_addr", {24'd0, rom_dir}, 32'd0);
    @(posedge clk); #1;
    check("single_gnt_pulse", {31'd0, gnt0}, 32'd0);
    drain();

    // Wrap-around burst from requester 1
    exp_word(1, 8'd101, 1'b0);
    exp_word(1, 8'd102, 1'b0);
    exp_word(1, 8'd90,  1'b0);
    exp_word(1, 8'd80,  1'b1);
    do_req(1'b1, 8'd10, 4'd4, w);
    for (int i = 0; i < 4; i++) begin
      check("wrap_romdir", {24'd0, rom_dir}, {24'd0, wrap_dir[i]});
      if (i < 3) begin @(posedge clk); #1; end
    end
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("dato_hold", {24'd0, dato}, 32'd80);

    // Contention from reset
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dir0 = 8'd9; dir1 = 8'd9; len0 = 4'd1; len1 = 4'd1;
    req0 = 1'b1; req1 = 1'b1;
    exp_word(0, 8'd100, 1'b1);
    exp_word(1, 8'd100, 1'b1);
    exp_word(0, 8'd100, 1'b1);
    got = 0;
    for (int c = 0; c < 30 && got < 3; c++) begin
      @(posedge clk); #1;
      if (gnt0 || gnt1) begin
        whos[got] = int'(gnt1);
        cyc[got]  = c;
        got++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_grant_count", got, 32'd3);
    if (got == 3) begin
      check("rr_first_edge", cyc[0], 32'd0);
      check("rr_order", {29'd0, whos[0][0], whos[1][0], whos[2][0]}, 32'b010);
      check("rr_gap1", cyc[1] - cyc[0], 32'd2);
      check("rr_gap2", cyc[2] - cyc[1], 32'd2);
    end
    drain();

    // Rejected bursts
    for (int i = 0; i < 3; i++) begin
      exp_err(0);
      do_req(1'b0, rej_dir[i], rej_len[i], w);
      @(posedge clk); #1;
      check("reject_err", {31'd0, err}, 32'd1);
      drain();
    end

    // Largest legal burst from the last address
    for (int i = 0; i < 12; i++) exp_word(1, bnd_data[i], i == 11);
    do_req(1'b1, 8'd11, 4'd12, w);
    drain();

    // Reset during a burst
    exp_word(0, 8'd40, 1'b0);
    exp_word(0, 8'd60, 1'b0);
    exp_word(0, 8'd70, 1'b0);
    do_req(1'b0, 8'd2, 4'd8, w);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_rst_flags", {25'd0, gnt0, gnt1, valid0, valid1, fin0, fin1, err}, 32'd0);
    check("async_rst_dato", {24'd0, dato}, 32'd0);
    check("async_rst_romdir", {24'd0, rom_dir}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_word(1, 8'd40, 1'b1);
    do_req(1'b1, 8'd5, 4'd1, w);
    check("post_rst_grant_latency", w, 32'd1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arb_rom.md
ARB_ROM -- requirements
Module: arb_rom

Interface
REQ-001 SHALL have parameter N_PAL, default 12, meaning the number of valid ROM words (addresses 0..N_PAL-1).
REQ-002 SHALL have parameter AW, default 8, meaning the address and data width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have ports req0 and req1, input, 1 bit each, burst request from requester 0 and requester 1.
REQ-006 SHALL have ports dir0 and dir1, input, AW bits each, burst start address per requester.
REQ-007 SHALL have ports len0 and len1, input, 4 bits each, burst length in words per requester.
REQ-008 SHALL have ports gnt0 and gnt1, output, 1 bit each, one-cycle grant pulse per requester.
REQ-009 SHALL have ports valid0 and valid1, output, 1 bit each, data-valid strobe for the owning requester.
REQ-010 SHALL have ports fin0 and fin1, output, 1 bit each, one-cycle end-of-burst pulse per requester.
REQ-011 SHALL have port err, output, 1 bit, one-cycle pulse flagging a rejected burst.
REQ-012 SHALL have port dato, output, AW bits, shared registered read data.
REQ-013 SHALL have port rom_dir, output, AW bits, address driven to the combinational ROM.
REQ-014 SHALL have port rom_dato, input, AW bits, ROM read data for the current rom_dir.

Function
REQ-015 SHALL implement the states IDLE, READ and ERR.
REQ-016 In IDLE, on an edge with any req high, the block SHALL select one owner.
REQ-017 On that edge the block SHALL latch the owner's dir/len, pulse that owner's gnt for exactly one cycle, and drive rom_dir to the start address.
REQ-018 Arbitration SHALL be round-robin: with both req high, the requester not served last wins; after reset requester 0 has priority.
REQ-019 A request SHALL be rejected to ERR when len=0, len>N_PAL, or dir>=N_PAL.
REQ-020 In ERR, at the next edge, the block SHALL pulse err and the owner's fin for one cycle, assert no valid, and return to IDLE.
REQ-021 In READ, at each edge, the block SHALL register dato <= rom_dato, raise the owner's valid, and decrement the remaining count.
REQ-022 In READ, rom_dir SHALL advance by 1, wrapping from N_PAL-1 to 0.
REQ-023 For a burst granted at edge k, words SHALL appear at edges k+1..k+len: ROM[start] first, one word per cycle, no gaps.
REQ-024 The owner's fin SHALL assert in the same cycle as its last valid.
REQ-025 After the last word the state SHALL be IDLE, so the earliest next grant is at edge k+len+1.
REQ-026 The non-owner's gnt, valid and fin SHALL stay 0 for the whole burst.
REQ-027 dato SHALL hold its last value while no valid is asserted.
REQ-028 Requests arriving during READ or ERR SHALL be ignored until IDLE; req must be held to be served.
REQ-029 Deasserting req, or changing dir/len, mid-burst SHALL have no effect; the burst completes.
REQ-030 No output SHALL depend combinationally on req, dir or len; every output is a registered signal.

Reset
REQ-031 While rst=1, the block SHALL force state=IDLE, rom_dir=0, dato=0, all gnt/valid/fin/err=0, and round-robin priority to requester 0, immediately and independent of clk.
REQ-032 Reset asserted mid-burst SHALL abort the burst with no fin; after release the block SHALL accept new requests from the first rising edge.

Verification (ROM preloaded 0:90 1:80 2:40 3:60 … 9:100 10:101 11:102)
REQ-033 Single burst: req0=1, dir0=0, len0=3 -> gnt0 one cycle; valid0 for 3 cycles with dato 90, 80, 40; fin0 with 40; gnt1/valid1 stay 0.
REQ-034 Wrap-around: req1=1, dir1=10, len1=4 -> dato 101, 102, 90, 80; rom_dir sequence 10, 11, 0, 1.
REQ-035 Contention: req0 and req1 held high, both dir=9, len=1, from reset -> requester 0 is served first (dato 100), then requester 1 (dato 100), then requester 0 again; exactly one idle cycle between bursts.
REQ-036 Rejection: req0 with dir0=12, len0=2 -> gnt0, then err+fin0 one cycle later, no valid0; same for len0=0 and len0=13.
REQ-037 Reset mid-burst: dir0=2, len0=8, rst pulsed after the 3rd word -> all outputs 0 asynchronously, no fin0; a new req1 with dir1=5, len1=1 after release returns 40.
